// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: the CPU port has fixed priority and the DMA port has a starvation bound.
// Read data returns one cycle after the grant and is tagged with the requesting port.
module ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              owner
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             rd_c_q, rd_c_d;
  logic             rd_d_q, rd_d_d;
  logic             force_dma_s;

  assign force_dma_s = (starve_q == STARVE_LIMIT);

  // One grant per cycle; the DMA port wins a contested cycle only once it has starved to the limit
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    owner = 1'b0;
    if (rst) begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      owner = 1'b0;
    end else if (c_req && !(d_req && force_dma_s)) begin
      c_gnt = 1'b1;
      owner = 1'b0;
    end else if (d_req) begin
      d_gnt = 1'b1;
      owner = 1'b1;
    end else begin
      owner = 1'b0;
    end
  end

  // RAM port mux follows the owner; an idle bus still presents the CPU address
  always_comb begin
    ram_addr   = c_addr;
    ram_w_data = c_wdata;
    ram_w_en   = 1'b0;
    if (owner) begin
      ram_addr   = d_addr;
      ram_w_data = d_wdata;
      ram_w_en   = d_we && d_gnt;
    end else begin
      ram_addr   = c_addr;
      ram_w_data = c_wdata;
      ram_w_en   = c_we && c_gnt;
    end
  end

  // Starvation counter saturates at the limit and never wraps
  always_comb begin
    starve_d = starve_q;
    if (d_gnt) begin
      starve_d = {CNT_W{1'b0}};
    end else if (d_req && (starve_q < STARVE_LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Read-return tags: remember which port issued a granted read
  always_comb begin
    rd_c_d = c_gnt && !c_we;
    rd_d_d = d_gnt && !d_we;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= {CNT_W{1'b0}};
      rd_c_q   <= 1'b0;
      rd_d_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_c_q   <= rd_c_d;
      rd_d_q   <= rd_d_d;
    end
  end

  // Both ports see the RAM read bus; only the rvalid tag qualifies it
  assign c_rvalid = rd_c_q;
  assign d_rvalid = rd_d_q;
  assign c_rdata  = ram_r_data;
  assign d_rdata  = ram_r_data;

endmodule
